serial_addsub: RTL
==================

// Module: serial_addsub
// PURPOSE
//  Parametrised bit-serial adder/subtractor with a built-in control FSM.
//  Latches two WIDTH-bit operands on a start handshake and processes one bit per clock, LSB first.
//  Uses a single full-adder cell and a carry flip-flop.
//  Deposits the result in a parallel output register and flags completion with a one-cycle done pulse.
//  Sits between a host register file and any consumer wanting a low-area adder.
// PARAMETERS
//  WIDTH  16  operand/result width in bits; legal range >= 2
// PORTS
//  clk        in   1      single clock; all state updates on posedge
//  reset      in   1      synchronous, active-high; clears all state
//  start      in   1      request; sampled only in IDLE
//  sub        in   1      0 = a+b, 1 = a-b; sampled with start
//  a          in   WIDTH  operand A; sampled with start
//  b          in   WIDTH  operand B; sampled with start
//  sum        out  WIDTH  result register
//  carry_out  out  1      add: carry out of MSB; sub: 1 = no borrow (a >= b unsigned)
//  overflow   out  1      two's-complement overflow: carry into MSB ^ carry out of MSB
//  busy       out  1      high in SHIFT state
//  done       out  1      one-cycle pulse in DONE state
// BEHAVIOUR
//  Reset: state=IDLE; sum=0, carry_out=0, overflow=0, busy=0, done=0; shift regs, counter and carry FF = 0.
//  FSM states:
//   - IDLE: start=1 at edge k loads A_sr<=a, B_sr<=(sub ? ~b : b), carry FF<=sub, cnt<=0; go to SHIFT.
//   - SHIFT: each edge k+1..k+WIDTH computes one full-add on A_sr[0], B_sr[0], carry.
//     Sum bit shifts into S_sr MSB; A_sr/B_sr shift right with 0 fill; carry FF <= cout; cnt++.
//     On the edge where cnt==WIDTH-1, go to DONE and update sum, carry_out, overflow.
//     overflow uses the carry into bit WIDTH-1, captured on that final edge.
//   - DONE: done=1 for exactly one cycle; next edge goes to IDLE.
//  Latency: start sampled at edge k; done high between edges k+WIDTH and k+WIDTH+1.
//   Results valid from edge k+WIDTH.
//   Minimum issue interval is WIDTH+2 cycles.
//  Results hold their value until the final edge of the next operation; they do not change mid-operation.
//  start while in SHIFT or DONE is ignored, with no queueing; start is level-sampled only in IDLE.
//  sub and the operands are don't-care except at the accepting edge.
//  Reset has priority over everything, including the start edge and mid-SHIFT.
//   It aborts the operation and clears outputs; the next start behaves as after power-up.
//  Counter width is $clog2(WIDTH); it never wraps past WIDTH-1.
//  Arithmetic is modulo 2^WIDTH; no output is wider than WIDTH except the carry/overflow flags.
// STRUCTURE
//  Shared package serial_arith_pkg:
//   - state typedef {IDLE, SHIFT, DONE} (2-bit);
//   - MODE_ADD=1'b0 / MODE_SUB=1'b1 constants.
//  One sub-module: serial_shift_reg #(WIDTH), a loadable right-shift PISO register with sync reset.
//   Instantiated for A and B; S_sr is a plain shift-in register.
//  FSM, counter, carry FF and the full-add equation live in the top.
// TESTING
//  1. WIDTH=16, add 0x1234+0x4321 -> sum=0x5555, carry_out=0, overflow=0.
//     busy high for 16 cycles; done pulses once, 16 edges after start.
//  2. add 0xFFFF+0x0001 -> sum=0x0000, carry_out=1, overflow=0.
//     add 0x7FFF+0x0001 -> sum=0x8000, carry_out=0, overflow=1.
//  3. sub 0x0005-0x0007 -> sum=0xFFFE, carry_out=0, overflow=0.
//     sub 0x8000-0x0001 -> sum=0x7FFF, carry_out=1, overflow=1.
//  4. Start 0x00FF+0x0F00, then pulse start again with new operands during SHIFT and in the DONE cycle.
//     -> both ignored; sum=0x0FFF; start on the cycle after DONE is accepted.
//  5. Assert reset 5 cycles into an operation -> next cycle busy=0, done=0, sum=0, flags=0.
//     A following add 0x0003+0x0004 -> sum=0x0007 with normal latency.
//  6. WIDTH=8, sub 0xFF-0x01 -> sum=0xFE, carry_out=1.
//     Check done arrives 8 edges after start.
//     Random add/sub regression checked against a reference model.

Source files
------------

// File: rtl/serial_arith_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : serial_arith_pkg
//  Description : Shared types and constants for the bit-serial arithmetic
//                blocks (FSM state encoding, add/subtract mode select).
//  Revision    : 1.0  initial release
// ============================================================================
package serial_arith_pkg;

  // Control FSM state encoding (2-bit)
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Operation select carried on the sub input
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage
`default_nettype wire

// File: rtl/serial_addsub_if.sv
`default_nettype none
// ============================================================================
//  Interface   : serial_addsub_if
//  Description : Request/result bundle between a host and serial_addsub.
//                The host drives the request side through the master modport;
//                the arithmetic unit returns results through the slave modport.
//  Revision    : 1.0  initial release
// ============================================================================
interface serial_addsub_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;
  logic             busy;
  logic             done;

  modport master (
    output start, sub, a, b,
    input  sum, carry_out, overflow, busy, done
  );

  modport slave (
    input  start, sub, a, b,
    output sum, carry_out, overflow, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/serial_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_shift_reg
//  Description : Loadable right-shift parallel-in/serial-out register with
//                synchronous reset. Zero is shifted in at the MSB; the serial
//                output is the current LSB.
//  Revision    : 1.0  initial release
// ============================================================================
module serial_shift_reg #(
  parameter int WIDTH = 16
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             load,
  input  wire logic             shift,
  input  wire logic [WIDTH-1:0] din,
  output logic                  lsb
);

  logic [WIDTH-1:0] r_q;

  // Parallel load has priority over shifting; both are mutually exclusive in use
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= din;
    end else if (shift) begin
      r_q <= {1'b0, r_q[WIDTH-1:1]};
    end
  end

  assign lsb = r_q[0];

endmodule
`default_nettype wire

// File: rtl/serial_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : serial_addsub
//  Description : Bit-serial adder/subtractor. Operands are latched on a start
//                request in IDLE and processed LSB first through one full-add
//                cell and a carry flip-flop. Results land in a parallel
//                register with a one-cycle done pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module serial_addsub #(
  parameter int WIDTH = 16
) (
  input  wire logic         clk,
  input  wire logic         reset,
  serial_addsub_if.slave    bus
);
  import serial_arith_pkg::*;

  localparam int              CNT_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_carry;
  logic [WIDTH-1:0]   r_s_sr;
  logic [WIDTH-1:0]   r_sum;
  logic               r_carry_out;
  logic               r_overflow;

  logic               w_load;
  logic               w_shift;
  logic               w_last;
  logic [WIDTH-1:0]   w_b_in;
  logic               w_a_bit;
  logic               w_b_bit;
  logic               w_sum_bit;
  logic               w_cout;

  assign w_load  = (r_state == IDLE) && bus.start;
  assign w_shift = (r_state == SHIFT);
  assign w_last  = w_shift && (r_cnt == c_CNT_LAST);
  // Subtraction is a + ~b + 1: invert B here, the +1 comes from the carry seed
  assign w_b_in  = (bus.sub == MODE_SUB) ? ~bus.b : bus.b;

  serial_shift_reg #(.WIDTH(WIDTH)) u_a_sr (
    .clk   (clk),
    .reset (reset),
    .load  (w_load),
    .shift (w_shift),
    .din   (bus.a),
    .lsb   (w_a_bit)
  );

  serial_shift_reg #(.WIDTH(WIDTH)) u_b_sr (
    .clk   (clk),
    .reset (reset),
    .load  (w_load),
    .shift (w_shift),
    .din   (w_b_in),
    .lsb   (w_b_bit)
  );

  // Single full-adder cell
  assign w_sum_bit = w_a_bit ^ w_b_bit ^ r_carry;
  assign w_cout    = (w_a_bit & w_b_bit) | (r_carry & (w_a_bit ^ w_b_bit));

  // Control FSM: IDLE -> SHIFT for WIDTH cycles -> DONE for one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE:    if (bus.start) r_state <= SHIFT;
        SHIFT:   if (w_last)    r_state <= DONE;
        DONE:                   r_state <= IDLE;
        default:                r_state <= IDLE;
      endcase
    end
  end

  // Serial datapath: bit counter, carry flip-flop and result shift-in register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_s_sr  <= '0;
    end else if (w_load) begin
      r_cnt   <= '0;
      r_carry <= bus.sub;
    end else if (w_shift) begin
      r_carry <= w_cout;
      r_s_sr  <= {w_sum_bit, r_s_sr[WIDTH-1:1]};
      // Counter holds at its last value instead of wrapping
      if (!w_last) r_cnt <= r_cnt + 1'b1;
    end
  end

  // Result registers update only on the final shift edge so they hold mid-operation
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sum       <= '0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (w_last) begin
      r_sum       <= {w_sum_bit, r_s_sr[WIDTH-1:1]};
      r_carry_out <= w_cout;
      // r_carry here is the carry into the MSB
      r_overflow  <= r_carry ^ w_cout;
    end
  end

  assign bus.sum       = r_sum;
  assign bus.carry_out = r_carry_out;
  assign bus.overflow  = r_overflow;
  assign bus.busy      = (r_state == SHIFT);
  assign bus.done      = (r_state == DONE);

endmodule
`default_nettype wire
